// File: rtl/render_pkg.sv
// Shared types and helpers for the render dispatcher: FSM states, pixel
// colour type and frame-buffer bank geometry.
package render_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  typedef logic [23:0] rgb_t;

  // Coordinates carry one spare code so a result lying past the image edge
  // can still be presented and flagged.
  function automatic int coord_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Word offset of the second frame-buffer bank: one full image further on.
  function automatic logic [31:0] bank_offset(input int w, input int h);
    return 32'(w * h);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter. Priority starts at the pointer lane and the
// pointer moves one past the granted lane whenever 'advance' is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;

  // Scan from the farthest lane back to the pointer so the closest requester wins
  always_comb begin
    int k;
    grant = '0;
    gidx  = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr_q) + i) % N;
      if (req[k[PW-1:0]]) begin
        grant            = '0;
        grant[k[PW-1:0]] = 1'b1;
        gidx             = k[PW-1:0];
      end
    end
  end

  // Hand priority to the lane after the one just served
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q <= '0;
    end else if (advance && (|grant)) begin
      ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/render_dispatcher.sv
// Raster-order pixel dispatcher for a set of shading lanes, with round-robin
// result writeback into a frame buffer.
// Optional feature: define RENDER_DOUBLE_BUFFER_EN for two frame-buffer banks
// and a vsync-synchronised bank swap between frames.
module render_dispatcher
  import render_pkg::*;
#(
  parameter  int WIDTH           = 1280,
  parameter  int HEIGHT          = 720,
  parameter  int N_LANES         = 4,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int XW              = coord_width(WIDTH),
  localparam int YW              = coord_width(HEIGHT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  output logic [N_LANES-1:0]           lane_valid_out,
  output logic [XW-1:0]                lane_x_out,
  output logic [YW-1:0]                lane_y_out,
  input  logic [N_LANES-1:0]           lane_ready_in,
  input  logic [N_LANES-1:0]           res_valid_in,
  input  logic [N_LANES-1:0][XW-1:0]   res_x_in,
  input  logic [N_LANES-1:0][YW-1:0]   res_y_in,
  input  rgb_t [N_LANES-1:0]           res_rgb_in,
  output logic [N_LANES-1:0]           res_ready_out,
  output logic                         fb_we_out,
  output logic [31:0]                  fb_addr_out,
  output rgb_t                         fb_data_out,
  input  logic                         vsync_in,
  output logic                         buf_sel_out,
  output logic                         frame_done_out,
  output logic                         bad_coord_out
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [CW-1:0]      out_q;
  logic               issue_en, issue, accept, last_pix;
  logic [N_LANES-1:0] issue_grant, wb_grant;
  logic [XW-1:0]      sel_x;
  logic [YW-1:0]      sel_y;
  rgb_t               sel_rgb;
  logic               in_range, back_bank;

  assign issue_en = (state_q == ST_ISSUE) && (out_q != CW'(MAX_OUTSTANDING));
  assign last_pix = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

  rr_arbiter #(.N(N_LANES)) u_issue_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     (lane_ready_in & {N_LANES{issue_en}}),
    .advance (issue),
    .grant   (issue_grant)
  );

  rr_arbiter #(.N(N_LANES)) u_wb_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     (res_valid_in),
    .advance (accept),
    .grant   (wb_grant)
  );

  assign lane_valid_out = issue_grant;
  assign issue          = |issue_grant;
  assign lane_x_out     = x_q;
  assign lane_y_out     = y_q;
  assign res_ready_out  = wb_grant;
  assign accept         = |wb_grant;

  // Route the granted lane's result onto the writeback path
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_rgb = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (wb_grant[i]) begin
        sel_x   = res_x_in[i];
        sel_y   = res_y_in[i];
        sel_rgb = res_rgb_in[i];
      end
    end
    in_range = (32'(sel_x) < 32'(WIDTH)) && (32'(sel_y) < 32'(HEIGHT));
  end

`ifdef RENDER_DOUBLE_BUFFER_EN
  assign back_bank = ~buf_sel_out;

  // Flip the displayed bank on the vsync that ends the swap wait
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_sel_out <= 1'b0;
    end else if ((state_q == ST_SWAP_WAIT) && vsync_in) begin
      buf_sel_out <= ~buf_sel_out;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync_in;
  assign back_bank    = 1'b0;
  assign buf_sel_out  = 1'b0;
`endif

  // Walk the raster cursor one pixel per issue, wrapping at the image edges
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q <= '0;
      y_q <= '0;
    end else if (issue) begin
      if (x_q == XW'(WIDTH - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Track pixels in flight; stray results after a reset cannot drive it below zero
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_q <= '0;
    end else begin
      case ({issue, accept})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   if (out_q != '0) out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
    end
  end

  // Dispatcher state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: issue the frame, drain it, then optionally wait for vsync
  always_comb begin
    state_d        = state_q;
    frame_done_out = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (issue && last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_q == '0) begin
          frame_done_out = 1'b1;
`ifdef RENDER_DOUBLE_BUFFER_EN
          state_d = ST_SWAP_WAIT;
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_SWAP_WAIT: begin
`ifdef RENDER_DOUBLE_BUFFER_EN
        if (vsync_in) state_d = ST_ISSUE;
`else
        state_d = ST_ISSUE;
`endif
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // Register accepted results into frame-buffer writes; out-of-range ones only raise the flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fb_we_out     <= 1'b0;
      fb_addr_out   <= '0;
      fb_data_out   <= '0;
      bad_coord_out <= 1'b0;
    end else begin
      fb_we_out <= accept && in_range;
      if (accept && in_range) begin
        fb_addr_out <= 32'(sel_x) + 32'(WIDTH) * 32'(sel_y)
                     + (back_bank ? bank_offset(WIDTH, HEIGHT) : 32'd0);
        fb_data_out <= sel_rgb;
      end
      if (accept && !in_range) bad_coord_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_render_dispatcher.sv
// Self-checking bench for render_dispatcher on a 4x2 image with two lanes.
module tb_render_dispatcher;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int N    = 2;
  localparam int MAXO = 2;
  localparam int XW   = $clog2(W + 1);
  localparam int YW   = $clog2(H + 1);
`ifdef RENDER_DOUBLE_BUFFER_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif
  localparam int OFS = DB * W * H;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
  } pix_t;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          lane_valid;
  logic [XW-1:0]         lane_x;
  logic [YW-1:0]         lane_y;
  logic [N-1:0]          lane_ready;
  logic [N-1:0]          res_valid;
  logic [N-1:0][XW-1:0]  res_x;
  logic [N-1:0][YW-1:0]  res_y;
  logic [N-1:0][23:0]    res_rgb;
  logic [N-1:0]          res_ready;
  logic                  fb_we;
  logic [31:0]           fb_addr;
  logic [23:0]           fb_data;
  logic                  vsync;
  logic                  buf_sel;
  logic                  frame_done;
  logic                  bad_coord;

  int tests_run    = 0;
  int tests_failed = 0;

  render_dispatcher #(
    .WIDTH(W), .HEIGHT(H), .N_LANES(N), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .lane_valid_out(lane_valid), .lane_x_out(lane_x), .lane_y_out(lane_y),
    .lane_ready_in(lane_ready), .res_valid_in(res_valid),
    .res_x_in(res_x), .res_y_in(res_y), .res_rgb_in(res_rgb),
    .res_ready_out(res_ready),
    .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
    .vsync_in(vsync), .buf_sel_out(buf_sel),
    .frame_done_out(frame_done), .bad_coord_out(bad_coord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin choice: first requester at or after ptr, -1 if none
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k = (ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive_idle();
    lane_ready = '0;
    res_valid  = '0;
    res_x      = '0;
    res_y      = '0;
    res_rgb    = '0;
    vsync      = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    pulse_reset();
    tests_run++; if (lane_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_lane_valid got %b want 00", lane_valid); end
    tests_run++; if (res_ready !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_res_ready got %b want 00", res_ready); end
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fb_we got %b want 0", fb_we); end
    tests_run++; if (fb_addr !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_fb_addr got %0d want 0", fb_addr); end
    tests_run++; if (fb_data !== 24'd0) begin tests_failed++; $display("[TB] FAIL reset_fb_data got %h want 0", fb_data); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
    tests_run++; if (bad_coord !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bad_coord got %b want 0", bad_coord); end
    tests_run++; if (buf_sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_buf_sel got %b want 0", buf_sel); end
    tests_run++; if (lane_x !== '0 || lane_y !== '0) begin tests_failed++; $display("[TB] FAIL reset_cursor got (%0d,%0d) want (0,0)", lane_x, lane_y); end
  endtask

  task automatic test_issue_limit();
    @(posedge clk); #1;
    lane_ready = 2'b11;
    @(negedge clk);
    tests_run++; if (lane_valid !== 2'b01 || lane_x !== 3'd0 || lane_y !== 2'd0) begin tests_failed++; $display("[TB] FAIL issue_first got %b (%0d,%0d) want 01 (0,0)", lane_valid, lane_x, lane_y); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (lane_valid !== 2'b10 || lane_x !== 3'd1 || lane_y !== 2'd0) begin tests_failed++; $display("[TB] FAIL issue_second got %b (%0d,%0d) want 10 (1,0)", lane_valid, lane_x, lane_y); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++; if (lane_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL issue_limit cycle %0d got %b want 00", c, lane_valid); end
    end
  endtask

  task automatic test_writeback();
    @(posedge clk); #1;
    lane_ready = 2'b00;
    res_valid  = 2'b10;
    res_x[1]   = XW'(3);
    res_y[1]   = YW'(1);
    res_rgb[1] = 24'hFF8000;
    @(negedge clk);
    tests_run++; if (res_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL wb_grant got %b want 10", res_ready); end
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL wb_early_we got %b want 0", fb_we); end
    @(posedge clk); #1;
    res_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (fb_we !== 1'b1 || fb_addr !== 32'(7 + OFS) || fb_data !== 24'hFF8000) begin tests_failed++; $display("[TB] FAIL wb_write got we=%b addr=%0d data=%h want we=1 addr=%0d data=ff8000", fb_we, fb_addr, fb_data, 7 + OFS); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL wb_we_drop got %b want 0", fb_we); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    res_valid  = 2'b11;
    res_x[0]   = XW'(0); res_y[0] = YW'(1); res_rgb[0] = 24'h112233;
    res_x[1]   = XW'(2); res_y[1] = YW'(1); res_rgb[1] = 24'h445566;
    @(negedge clk);
    tests_run++; if (res_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL b2b_grant0 got %b want 01", res_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (res_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL b2b_grant1 got %b want 10", res_ready); end
    tests_run++; if (fb_we !== 1'b1 || fb_addr !== 32'(4 + OFS) || fb_data !== 24'h112233) begin tests_failed++; $display("[TB] FAIL b2b_write0 got we=%b addr=%0d data=%h want we=1 addr=%0d data=112233", fb_we, fb_addr, fb_data, 4 + OFS); end
    @(posedge clk); #1;
    res_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (fb_we !== 1'b1 || fb_addr !== 32'(6 + OFS) || fb_data !== 24'h445566) begin tests_failed++; $display("[TB] FAIL b2b_write1 got we=%b addr=%0d data=%h want we=1 addr=%0d data=445566", fb_we, fb_addr, fb_data, 6 + OFS); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_we_drop got %b want 0", fb_we); end
  endtask

  task automatic test_bad_coord();
    int issues;
    @(posedge clk); #1;
    res_valid = 2'b01;
    res_x[0]  = XW'(5);
    res_y[0]  = YW'(0);
    @(negedge clk);
    tests_run++; if (res_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL bad_accept got %b want 01", res_ready); end
    @(posedge clk); #1;
    res_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL bad_no_write got %b want 0", fb_we); end
    tests_run++; if (bad_coord !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_flag got %b want 1", bad_coord); end
    // Nothing is outstanding now, so exactly MAXO issues may follow
    issues = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      lane_ready = 2'b11;
      @(negedge clk);
      if (lane_valid != 2'b00) issues++;
    end
    lane_ready = 2'b00;
    tests_run++; if (issues != MAXO) begin tests_failed++; $display("[TB] FAIL no_underflow_issues got %0d want %0d", issues, MAXO); end
    tests_run++; if (bad_coord !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_sticky got %b want 1", bad_coord); end
  endtask

  task automatic test_reset_drain();
    int issued;
    int pending;
    pulse_reset();
    issued  = 0;
    pending = 0;
    for (int c = 0; c < 80 && issued < W * H; c++) begin
      @(posedge clk); #1;
      lane_ready   = 2'b11;
      res_valid    = {1'b0, (pending == MAXO)};
      res_x[0]     = '0;
      res_y[0]     = '0;
      @(negedge clk);
      if (lane_valid != 2'b00) begin issued++; pending++; end
      if (res_ready[0]) pending--;
    end
    tests_run++; if (issued != W * H || pending != 2) begin tests_failed++; $display("[TB] FAIL drain_setup got issued=%0d pending=%0d want %0d and 2", issued, pending, W * H); end
    @(posedge clk); #1;
    res_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (lane_valid !== 2'b00 || frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_idle got valid=%b done=%b want 00 0", lane_valid, frame_done); end
    @(posedge clk); #1;
    rst        = 1'b1;
    lane_ready = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (lane_valid !== 2'b00 || res_ready !== 2'b00 || fb_we !== 1'b0 || frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_reset_strobes got valid=%b ready=%b we=%b done=%b want all 0", lane_valid, res_ready, fb_we, frame_done); end
    tests_run++; if (fb_addr !== 32'd0 || fb_data !== 24'd0 || buf_sel !== 1'b0 || bad_coord !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_reset_regs got addr=%0d data=%h sel=%b bad=%b want all 0", fb_addr, fb_data, buf_sel, bad_coord); end
    tests_run++; if (lane_x !== '0 || lane_y !== '0) begin tests_failed++; $display("[TB] FAIL drain_reset_cursor got (%0d,%0d) want (0,0)", lane_x, lane_y); end
    @(posedge clk); #1;
    lane_ready = 2'b11;
    @(negedge clk);
    tests_run++; if (lane_valid !== 2'b01 || lane_x !== '0 || lane_y !== '0) begin tests_failed++; $display("[TB] FAIL drain_restart got %b (%0d,%0d) want 01 (0,0)", lane_valid, lane_x, lane_y); end
  endtask

  task automatic test_random_frames();
    pix_t        q0[$];
    pix_t        q1[$];
    pix_t        p;
    int          phase, outst, iss_ptr, wb_ptr, cx, cy, bs, frames, writes;
    int          ip, wp, exp_addr, old_phase;
    logic        exp_we, exp_fd;
    logic [31:0] nxt_addr;
    logic [23:0] exp_data;
    logic [N-1:0] exp_lv, exp_rr, rv;
    pulse_reset();
    phase = 0; outst = 0; iss_ptr = 0; wb_ptr = 0; cx = 0; cy = 0; bs = 0;
    frames = 0; writes = 0; exp_we = 1'b0; exp_data = '0; exp_addr = 0;
    for (int c = 0; c < 3000 && frames < 2; c++) begin
      @(posedge clk); #1;
      lane_ready = N'($urandom_range(0, 3));
      vsync      = ($urandom_range(0, 5) == 0);
      rv         = '0;
      res_x      = N*XW'($urandom);
      res_y      = N*YW'($urandom);
      res_rgb    = 48'({$urandom, $urandom});
      if (q0.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv[0] = 1'b1; res_x[0] = XW'(q0[0].x); res_y[0] = YW'(q0[0].y); res_rgb[0] = q0[0].rgb;
      end
      if (q1.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv[1] = 1'b1; res_x[1] = XW'(q1[0].x); res_y[1] = YW'(q1[0].y); res_rgb[1] = q1[0].rgb;
      end
      res_valid = rv;
      @(negedge clk);
      ip = (phase == 0 && outst < MAXO) ? rr_pick(lane_ready, iss_ptr) : -1;
      exp_lv = '0;
      if (ip >= 0) exp_lv[ip] = 1'b1;
      wp = rr_pick(res_valid, wb_ptr);
      exp_rr = '0;
      if (wp >= 0) exp_rr[wp] = 1'b1;
      exp_fd = (phase == 1 && outst == 0);
      tests_run++; if (lane_valid !== exp_lv) begin tests_failed++; $display("[TB] FAIL rnd_issue cycle %0d got %b want %b", c, lane_valid, exp_lv); end
      if (ip >= 0) begin
        tests_run++; if (lane_x !== XW'(cx) || lane_y !== YW'(cy)) begin tests_failed++; $display("[TB] FAIL rnd_coord cycle %0d got (%0d,%0d) want (%0d,%0d)", c, lane_x, lane_y, cx, cy); end
      end
      tests_run++; if (res_ready !== exp_rr) begin tests_failed++; $display("[TB] FAIL rnd_wb_grant cycle %0d got %b want %b", c, res_ready, exp_rr); end
      tests_run++; if (fb_we !== exp_we) begin tests_failed++; $display("[TB] FAIL rnd_we cycle %0d got %b want %b", c, fb_we, exp_we); end
      if (exp_we) begin
        tests_run++; if (fb_addr !== 32'(exp_addr) || fb_data !== exp_data) begin tests_failed++; $display("[TB] FAIL rnd_write cycle %0d got %0d/%h want %0d/%h", c, fb_addr, fb_data, exp_addr, exp_data); end
      end
      tests_run++; if (frame_done !== exp_fd) begin tests_failed++; $display("[TB] FAIL rnd_frame_done cycle %0d got %b want %b", c, frame_done, exp_fd); end
      tests_run++; if (buf_sel !== 1'(bs) || bad_coord !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_flags cycle %0d got sel=%b bad=%b want sel=%0d bad=0", c, buf_sel, bad_coord, bs); end
      // Advance the reference model across the coming clock edge
      exp_we = 1'b0;
      if (wp >= 0) begin
        if (wp == 0) p = q0.pop_front(); else p = q1.pop_front();
        exp_we   = 1'b1;
        exp_data = p.rgb;
        exp_addr = p.x + W * p.y + ((DB == 1 && bs == 0) ? W * H : 0);
        nxt_addr = 32'(exp_addr);
        writes++;
        wb_ptr = (wp + 1) % N;
      end
      old_phase = phase;
      if (ip >= 0) begin
        p.x = cx; p.y = cy; p.rgb = 24'($urandom);
        if (ip == 0) q0.push_back(p); else q1.push_back(p);
        iss_ptr = (ip + 1) % N;
        if (cx == W - 1 && cy == H - 1) phase = 1;
        cx = cx + 1;
        if (cx == W) begin cx = 0; cy = (cy + 1) % H; end
      end
      if (ip >= 0 && wp < 0) outst++;
      else if (ip < 0 && wp >= 0 && outst > 0) outst--;
      if (old_phase == 1 && exp_fd) begin
        frames++;
        phase = (DB == 1) ? 2 : 0;
      end else if (old_phase == 2 && vsync) begin
        bs    = 1 - bs;
        phase = 0;
      end
    end
    drive_idle();
    tests_run++; if (frames != 2) begin tests_failed++; $display("[TB] FAIL rnd_frames got %0d want 2 within budget", frames); end
    tests_run++; if (writes != 2 * W * H) begin tests_failed++; $display("[TB] FAIL rnd_writes got %0d want %0d", writes, 2 * W * H); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_issue_limit();
    test_writeback();
    test_back_to_back();
    test_bad_coord();
    test_reset_drain();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/render_dispatcher.md
RENDER_DISPATCHER -- requirements
Module: render_dispatcher

Interface
REQ-001 Parameter WIDTH, default 1280, rendered image width in pixels.
REQ-002 Parameter HEIGHT, default 720, rendered image height in pixels.
REQ-003 Parameter N_LANES, default 4, number of pixel-shading lanes served.
REQ-004 Parameter MAX_OUTSTANDING, default 16, maximum pixels issued but not yet written back.
REQ-005 clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 lane_valid_out  output  N_LANES  one-hot issue strobe, at most one bit high per cycle.
REQ-008 lane_x_out / lane_y_out  output  clog2(WIDTH) / clog2(HEIGHT)  pixel coordinates broadcast to all lanes.
REQ-009 lane_ready_in  input  N_LANES  lane i accepts a pixel.
REQ-010 res_valid_in  input  N_LANES  lane i presents a result.
REQ-011 res_x_in / res_y_in  input  N_LANES x coord width  result coordinates per lane.
REQ-012 res_rgb_in  input  N_LANES x 24  result colour {R,G,B}, 8 bits each.
REQ-013 res_ready_out  output  N_LANES  one-hot writeback grant.
REQ-014 fb_we_out, fb_addr_out[31:0], fb_data_out[23:0]  output  frame-buffer write port.
REQ-015 vsync_in  input  1  single-cycle display frame-boundary pulse.
REQ-016 buf_sel_out  output  1  bank the display reads.
REQ-017 frame_done_out  output  1  single-cycle pulse when a full frame is written back.
REQ-018 bad_coord_out  output  1  sticky flag: out-of-range result received.

Function
REQ-019 Dispatcher FSM states: ISSUE, DRAIN, SWAP_WAIT.
REQ-020 ISSUE: round-robin grant among ready lanes, starting one past the last granted lane; issue occurs when granted lane's lane_valid_out and lane_ready_in are both high.
REQ-021 No issue while outstanding == MAX_OUTSTANDING; lane_valid_out all zero then.
REQ-022 Raster cursor advances after each issue: x wraps WIDTH-1 -> 0 with y+1; y wraps HEIGHT-1 -> 0.
REQ-023 Issuing pixel (WIDTH-1, HEIGHT-1) moves FSM ISSUE -> DRAIN next cycle.
REQ-024 DRAIN: no issue; when outstanding == 0, pulse frame_done_out one cycle and go to SWAP_WAIT (DOUBLE_BUFFER_EN) or ISSUE (otherwise).
REQ-025 SWAP_WAIT: on vsync_in, toggle buf_sel_out and enter ISSUE next cycle; vsync_in ignored in ISSUE and DRAIN.
REQ-026 Writeback: round-robin grant among res_valid_in, independent of dispatcher state; res_ready_out is that one-hot grant, combinational.
REQ-027 Accepted result writes one cycle later: fb_we_out=1, fb_data_out=res_rgb, fb_addr_out=x+WIDTH*y (+WIDTH*HEIGHT when back bank is 1); at most one write per cycle.
REQ-028 Result with x>=WIDTH or y>=HEIGHT: still accepted and counted, no write, bad_coord_out set until reset.
REQ-029 Outstanding counter: +1 per issue, -1 per accepted result, unchanged on simultaneous; never under/overflows.

Reset
REQ-030 Reset: state ISSUE, cursor (0,0), both round-robin pointers lane 0, outstanding 0, buf_sel_out 0.
REQ-031 Reset: lane_valid_out, res_ready_out, fb_we_out, frame_done_out, bad_coord_out all 0; fb_addr_out, fb_data_out 0.
REQ-032 Reset mid-frame abandons in-flight pixels; results arriving after reset are treated as new.

Configuration
REQ-033 Macro RENDER_DOUBLE_BUFFER_EN defined: two banks, rendering into bank ~buf_sel_out, SWAP_WAIT present.
REQ-034 Macro undefined: single bank, bank offset always 0, buf_sel_out constant 0, DRAIN returns directly to ISSUE.

Structure
REQ-035 Package render_pkg holds the FSM state enum, 24-bit rgb typedef and bank-offset constant.
REQ-036 Sub-module rr_arbiter (N-way round-robin, request/grant/advance) instantiated twice: issue and writeback.

Verification (WIDTH=4, HEIGHT=2, N_LANES=2, MAX_OUTSTANDING=2)
REQ-037 Both lanes always ready, no results -> issues (0,0) lane0, (1,0) lane1, then no issue until a result is accepted.
REQ-038 Lane1 returns (3,1) rgb 0xFF8000 -> one cycle later fb_we_out=1, fb_addr_out=7 (+8 with double buffer, buf_sel 0), fb_data_out=0xFF8000.
REQ-039 Both res_valid_in high for 2 cycles -> grants lane0 then lane1, two writes on consecutive cycles.
REQ-040 All 8 pixels returned -> single frame_done_out pulse; with double buffer, vsync_in pulse -> buf_sel_out=1, next frame writes addresses 0..7.
REQ-041 Result (5,0) -> accepted, no fb write, bad_coord_out=1 and stays 1.
REQ-042 rst_in asserted in DRAIN with 2 outstanding -> next cycle all outputs at reset values, cursor (0,0).
